clk_div_bank: RTL

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank_if.sv | 36 +++
 rtl/clk_div_bank.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/clk_div_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank_if
// Description : Configuration, resync and per-channel output bundle of the
//               clock-divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_bank_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 16
);
    localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [c_CH_W-1:0] cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_duty;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_en;
    logic              sync_all;
    logic [N_CH-1:0]   ce;
    logic [N_CH-1:0]   clkout;
    logic [N_CH-1:0]   lock;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_duty, cfg_phase, cfg_en, sync_all,
        input  cfg_ready, ce, clkout, lock
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_duty, cfg_phase, cfg_en, sync_all,
        output cfg_ready, ce, clkout, lock
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Bank of N_CH programmable dividers producing clock-enable
//               pulses, square waves and a settled (lock) flag per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16,
    parameter int LOCK_CYC = 16
) (
    input  wire           clkin,
    input  wire           reset,
    clk_div_bank_if.slave bus
);
    localparam int                c_CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int                c_LK_W     = (LOCK_CYC > 0) ? $clog2(LOCK_CYC + 1) : 1;
    localparam logic [c_LK_W-1:0] c_LK_MAX   = c_LK_W'(LOCK_CYC);
    localparam logic [0:0]        c_ST_IDLE  = 1'b0;
    localparam logic [0:0]        c_ST_APPLY = 1'b1;

    logic [0:0]        r_state;
    logic [c_CH_W-1:0] r_cfg_ch;
    logic [DIV_W-1:0]  r_cfg_div;
    logic [DIV_W-1:0]  r_cfg_duty;
    logic [DIV_W-1:0]  r_cfg_phase;
    logic              r_cfg_en;

    logic              w_xfer;
    logic              w_apply;
    logic [DIV_W-1:0]  w_load_new;
    logic [N_CH-1:0]   w_ce;
    logic [N_CH-1:0]   w_clkout;
    logic [N_CH-1:0]   w_lock;

    assign w_xfer     = bus.cfg_valid && (r_state == c_ST_IDLE);
    assign w_apply    = (r_state == c_ST_APPLY);
    assign w_load_new = (r_cfg_phase > r_cfg_div) ? r_cfg_div : r_cfg_phase;

    assign bus.cfg_ready = (r_state == c_ST_IDLE);
    assign bus.ce        = w_ce;
    assign bus.clkout    = w_clkout;
    assign bus.lock      = w_lock;

    // Two-state config port: the captured word is written on the APPLY cycle.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cfg_ch    <= '0;
            r_cfg_div   <= '0;
            r_cfg_duty  <= '0;
            r_cfg_phase <= '0;
            r_cfg_en    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_xfer) begin
                        r_state     <= c_ST_APPLY;
                        r_cfg_ch    <= bus.cfg_ch;
                        r_cfg_div   <= bus.cfg_div;
                        r_cfg_duty  <= bus.cfg_duty;
                        r_cfg_phase <= bus.cfg_phase;
                        r_cfg_en    <= bus.cfg_en;
                    end
                end
                c_ST_APPLY: r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // An out-of-range channel number simply matches no index here.
        localparam logic [c_CH_W-1:0] c_IDX = c_CH_W'(i);

        logic [DIV_W-1:0]  r_div;
        logic [DIV_W-1:0]  r_duty;
        logic [DIV_W-1:0]  r_phase;
        logic [DIV_W-1:0]  r_cnt;
        logic              r_en;
        logic              r_ce;
        logic              r_clkout;
        logic              r_lock;
        logic [c_LK_W-1:0] r_lk_cnt;

        logic              w_sel;
        logic [DIV_W-1:0]  w_load_old;
        logic [DIV_W-1:0]  w_cnt_wrap;
        logic [c_LK_W-1:0] w_lk_nxt;

        assign w_sel      = w_apply && (r_cfg_ch == c_IDX);
        assign w_load_old = (r_phase > r_div) ? r_div : r_phase;
        assign w_cnt_wrap = (r_cnt >= r_div) ? '0 : (r_cnt + DIV_W'(1));

        always_comb begin
            w_lk_nxt = r_lk_cnt;
            if (w_sel || !r_en) begin
                w_lk_nxt = '0;
            end else if (r_lk_cnt != c_LK_MAX) begin
                w_lk_nxt = r_lk_cnt + c_LK_W'(1);
            end
        end

        always_ff @(posedge clkin) begin
            if (reset) begin
                r_div    <= '0;
                r_duty   <= '0;
                r_phase  <= '0;
                r_cnt    <= '0;
                r_en     <= 1'b0;
                r_ce     <= 1'b0;
                r_clkout <= 1'b0;
                r_lock   <= 1'b0;
                r_lk_cnt <= '0;
            end else begin
                r_ce     <= r_en && (r_cnt == '0);
                r_clkout <= r_en && (r_cnt < r_duty);
                r_lk_cnt <= w_lk_nxt;
                r_lock   <= (w_lk_nxt == c_LK_MAX);

                // A fresh config wins over sync_all for the channel being applied.
                if (w_sel) begin
                    r_div   <= r_cfg_div;
                    r_duty  <= r_cfg_duty;
                    r_phase <= r_cfg_phase;
                    r_en    <= r_cfg_en;
                    r_cnt   <= r_cfg_en ? w_load_new : '0;
                end else if (!r_en) begin
                    r_cnt <= '0;
                end else if (bus.sync_all) begin
                    r_cnt <= w_load_old;
                end else begin
                    r_cnt <= w_cnt_wrap;
                end
            end
        end

        assign w_ce[i]     = r_ce;
        assign w_clkout[i] = r_clkout;
        assign w_lock[i]   = r_lock;
    end
endmodule
`default_nettype wire
